// File: rtl/uart_tx_fifo.sv
// ============================================================================
// uart_tx_fifo
//
// Buffered UART transmitter. Bytes are written into a small FIFO and sent as
// 8N1 frames (optionally 8E1/8O1), LSB first. Each bit lasts CLKS_PER_BIT
// cycles of txclk. Consecutive frames are sent with no idle gap for as long
// as the FIFO has data and tx_enable is high.
//
// Parameters
//   CLKS_PER_BIT  txclk cycles per serial bit (2..65535)
//   FIFO_DEPTH    FIFO entries, power of 2 in 2..16
//   PARITY_EN     1 inserts a parity bit between data bit 7 and the stop bit
//   PARITY_ODD    0 = even parity, 1 = odd parity (only used if PARITY_EN)
//
// Ports
//   txclk         clock, all logic on the rising edge
//   reset_n       asynchronous active-low reset
//   ld_tx_data    write strobe, pushes tx_data every cycle it is high
//   tx_data       byte to push
//   tx_enable     permits starting new frames
//   clr_over_run  clears tx_over_run
//   tx_out        serial line, idles high
//   tx_full       FIFO holds FIFO_DEPTH entries
//   tx_empty      FIFO empty and FSM idle
//   tx_busy       FSM not idle
//   tx_count      FIFO occupancy 0..FIFO_DEPTH
//   tx_over_run   sticky, set when a write is dropped because FIFO is full
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | line high, waiting for tx_enable and a byte in the FIFO
// S_START  | start bit, line low for one bit time
// S_DATA   | data bits 0..7, line = shift_q[0]
// S_PARITY | parity bit of the popped byte (only when PARITY_EN)
// S_STOP   | stop bit, line high; may chain straight into the next START
// ============================================================================
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic       txclk,
    input  logic       reset_n,
    input  logic       ld_tx_data,
    input  logic [7:0] tx_data,
    input  logic       tx_enable,
    input  logic       clr_over_run,
    output logic       tx_out,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       tx_busy,
    output logic [4:0] tx_count,
    output logic       tx_over_run
);

    localparam int unsigned       BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned       PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [4:0]        DEPTH_CNT = 5'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t            state_q,    state_d;
    logic [BAUD_W-1:0] baud_q,     baud_d;
    logic [2:0]        bit_idx_q,  bit_idx_d;
    logic [7:0]        shift_q,    shift_d;
    logic              par_q,      par_d;
    logic              tx_out_q,   tx_out_d;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [4:0]        count_q,    count_d;
    logic              over_run_q, over_run_d;

    logic              full_q;
    logic              empty_q;
    logic              busy_q;

    // ------------------------------------------------------------------
    // Common terms
    // ------------------------------------------------------------------
    logic       push;
    logic       pop;
    logic       has_data;
    logic       bit_end;
    logic [7:0] head;
    logic       head_par;

    // full_q is the registered view of count_q == FIFO_DEPTH, so a write is
    // judged against the occupancy at the start of the cycle; a pop in the
    // same cycle does not rescue it.
    assign push     = ld_tx_data && !full_q;
    assign has_data = (count_q != 5'd0);
    assign bit_end  = (baud_q == BAUD_LAST);
    assign head     = mem_q[rd_ptr_q];
    // Parity is captured from the byte at pop time, before it is shifted out.
    assign head_par = (^head) ^ PARITY_ODD;

    // ------------------------------------------------------------------
    // Transmit FSM next state. tx_out_d is the line value for the state
    // being entered, so tx_out is a plain register with no input-to-output
    // combinational path.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tx_out_d  = tx_out_q;
        pop       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                tx_out_d = 1'b1;
                if (tx_enable && has_data) begin
                    pop      = 1'b1;
                    state_d  = S_START;
                    baud_d   = '0;
                    shift_d  = head;
                    par_d    = head_par;
                    tx_out_d = 1'b0;
                end
            end

            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    tx_out_d  = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        if (PARITY_EN) begin
                            state_d  = S_PARITY;
                            tx_out_d = par_q;
                        end else begin
                            state_d  = S_STOP;
                            tx_out_d = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_out_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    state_d  = S_STOP;
                    baud_d   = '0;
                    tx_out_d = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    // Chain into the next frame without an idle bit.
                    if (tx_enable && has_data) begin
                        pop      = 1'b1;
                        state_d  = S_START;
                        shift_d  = head;
                        par_d    = head_par;
                        tx_out_d = 1'b0;
                    end else begin
                        state_d  = S_IDLE;
                        tx_out_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: begin
                state_d  = S_IDLE;
                baud_d   = '0;
                tx_out_d = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping and overrun flag
    // ------------------------------------------------------------------
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (push && !pop) begin
            count_d = count_q + 5'd1;
        end else if (!push && pop) begin
            count_d = count_q - 5'd1;
        end

        // Depth is a power of two, so pointers wrap naturally.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // Set has priority over clear.
        over_run_d = over_run_q;
        if (clr_over_run) begin
            over_run_d = 1'b0;
        end
        if (ld_tx_data && full_q) begin
            over_run_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State, datapath and registered status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge txclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            tx_out_q   <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= 5'd0;
            over_run_q <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tx_out_q   <= tx_out_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            over_run_q <= over_run_d;
            full_q     <= (count_d == DEPTH_CNT);
            empty_q    <= (count_d == 5'd0) && (state_d == S_IDLE);
            busy_q     <= (state_d != S_IDLE);
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge txclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    assign tx_out      = tx_out_q;
    assign tx_full     = full_q;
    assign tx_empty    = empty_q;
    assign tx_busy     = busy_q;
    assign tx_count    = count_q;
    assign tx_over_run = over_run_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo. Four instances: default parameters (sel 0),
// even parity (sel 1), odd parity (sel 2) and CLKS_PER_BIT=2 (sel 3).
// Instances 1..3 share one set of inputs.
module tb_uart_tx_fifo;

    logic       txclk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ld0 = 1'b0, en0 = 1'b0, clr0 = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic       ld1 = 1'b0, en1 = 1'b0, clr1 = 1'b0;
    logic [7:0] data1 = 8'h00;

    wire  [3:0] line_w;
    wire  [3:0] full_w;
    wire  [3:0] empty_w;
    wire  [3:0] busy_w;
    wire  [3:0] ovr_w;
    wire  [4:0] cnt_w [4];

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q [$];

    always #5 txclk = ~txclk;

    uart_tx_fifo u_dflt (
        .txclk(txclk), .reset_n(reset_n), .ld_tx_data(ld0), .tx_data(data0),
        .tx_enable(en0), .clr_over_run(clr0), .tx_out(line_w[0]),
        .tx_full(full_w[0]), .tx_empty(empty_w[0]), .tx_busy(busy_w[0]),
        .tx_count(cnt_w[0]), .tx_over_run(ovr_w[0])
    );

    uart_tx_fifo #(.CLKS_PER_BIT(16), .FIFO_DEPTH(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_even (
        .txclk(txclk), .reset_n(reset_n), .ld_tx_data(ld1), .tx_data(data1),
        .tx_enable(en1), .clr_over_run(clr1), .tx_out(line_w[1]),
        .tx_full(full_w[1]), .tx_empty(empty_w[1]), .tx_busy(busy_w[1]),
        .tx_count(cnt_w[1]), .tx_over_run(ovr_w[1])
    );

    uart_tx_fifo #(.CLKS_PER_BIT(16), .FIFO_DEPTH(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
        .txclk(txclk), .reset_n(reset_n), .ld_tx_data(ld1), .tx_data(data1),
        .tx_enable(en1), .clr_over_run(clr1), .tx_out(line_w[2]),
        .tx_full(full_w[2]), .tx_empty(empty_w[2]), .tx_busy(busy_w[2]),
        .tx_count(cnt_w[2]), .tx_over_run(ovr_w[2])
    );

    uart_tx_fifo #(.CLKS_PER_BIT(2), .FIFO_DEPTH(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_fast (
        .txclk(txclk), .reset_n(reset_n), .ld_tx_data(ld1), .tx_data(data1),
        .tx_enable(en1), .clr_over_run(clr1), .tx_out(line_w[3]),
        .tx_full(full_w[3]), .tx_empty(empty_w[3]), .tx_busy(busy_w[3]),
        .tx_count(cnt_w[3]), .tx_over_run(ovr_w[3])
    );

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge txclk);
        #1;
    endtask

    function automatic logic line_of(input int sel);
        return line_w[sel];
    endfunction

    function automatic int cpb_of(input int sel);
        return (sel == 3) ? 2 : 16;
    endfunction

    // Reference frame: start 0, data LSB first, optional parity, stop 1.
    function automatic int frame_bits(input logic [7:0] b, input int sel, output logic [10:0] bits);
        int n;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
        n = 9;
        if (sel == 1 || sel == 2) begin
            // even: total ones incl. parity bit is even; odd: total is odd
            bits[9] = (($countones(b) % 2) == 1) ^ (sel == 2);
            n = 10;
        end
        bits[n] = 1'b1;
        return n + 1;
    endfunction

    // Called on cycle 0 of a start bit; walks the whole frame checking that
    // every cycle of every bit carries the expected level. Optional action at
    // one cycle: 1 = drop en0, 2 = push act_data on u_dflt.
    task automatic expect_frame(input int sel, input logic [7:0] b, input int act_cyc,
                                input int act, input logic [7:0] act_data);
        logic [10:0] bits;
        int          nb;
        int          cyc;
        logic        seen;
        nb  = frame_bits(b, sel, bits);
        cyc = 0;
        for (int k = 0; k < nb; k++) begin
            seen = bits[k];
            for (int c = 0; c < cpb_of(sel); c++) begin
                if (line_of(sel) !== bits[k]) seen = line_of(sel);
                if (cyc == act_cyc) begin
                    if (act == 1) en0 = 1'b0;
                    if (act == 2) begin ld0 = 1'b1; data0 = act_data; end
                end
                tick();
                if (cyc == act_cyc && act == 2) ld0 = 1'b0;
                cyc++;
            end
            chk($sformatf("s%0d_byte%02h_bit%0d", sel, b, k), seen, bits[k]);
        end
    endtask

    task automatic wait_start(input int sel, input int max_cyc, output bit ok);
        int n;
        n = 0;
        while (line_of(sel) !== 1'b0 && n < max_cyc) begin
            tick();
            n++;
        end
        ok = (line_of(sel) === 1'b0);
        chk($sformatf("s%0d_start_seen", sel), ok, 1);
    endtask

    task automatic check_reset_vals(input int s);
        chk($sformatf("rst_s%0d_tx_out", s),   line_w[s],  1);
        chk($sformatf("rst_s%0d_full", s),     full_w[s],  0);
        chk($sformatf("rst_s%0d_empty", s),    empty_w[s], 1);
        chk($sformatf("rst_s%0d_busy", s),     busy_w[s],  0);
        chk($sformatf("rst_s%0d_count", s),    cnt_w[s],   0);
        chk($sformatf("rst_s%0d_over_run", s), ovr_w[s],   0);
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        bit         ok;
        int         errs;
        logic [7:0] b1, b2;
        logic [7:0] cb [5];

        // Reset held with random inputs
        reset_n = 1'b0;
        repeat (6) begin
            ld0 = 1'($urandom); data0 = 8'($urandom); en0 = 1'($urandom); clr0 = 1'($urandom);
            ld1 = 1'($urandom); data1 = 8'($urandom); en1 = 1'($urandom); clr1 = 1'($urandom);
            tick();
        end
        for (int s = 0; s < 4; s++) check_reset_vals(s);
        ld0 = 0; en0 = 0; clr0 = 0; ld1 = 0; en1 = 0; clr1 = 0;
        reset_n = 1'b1;
        tick(); tick();

        // Single byte 0xA5 with exact first-frame latency
        en0 = 1'b1;
        ld0 = 1'b1; data0 = 8'hA5;
        tick();
        ld0 = 1'b0;
        chk("single_count_after_write", cnt_w[0], 1);
        chk("single_line_after_write",  line_w[0], 1);
        chk("single_busy_after_write",  busy_w[0], 0);
        tick();
        chk("single_line_fall", line_w[0], 0);
        chk("single_busy_high", busy_w[0], 1);
        chk("single_count_pop", cnt_w[0], 0);
        expect_frame(0, 8'hA5, -1, 0, 8'h00);
        chk("single_empty_at_160", empty_w[0], 1);
        chk("single_busy_at_160",  busy_w[0],  0);

        // Burst to full with enable low; 9th write dropped, set beats clear
        en0 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            ld0 = 1'b1; data0 = 8'(i);
            clr0 = (i == 8);
            tick();
            if (i == 7) begin
                chk("burst_full_after8",  full_w[0], 1);
                chk("burst_count_after8", cnt_w[0],  8);
                chk("burst_ovr_after8",   ovr_w[0],  0);
            end
        end
        ld0 = 1'b0; clr0 = 1'b0;
        chk("burst_ovr_set_wins", ovr_w[0], 1);
        chk("burst_count_after9", cnt_w[0], 8);
        en0 = 1'b1;
        tick();
        chk("burst_first_start", line_w[0], 0);
        chk("burst_count_pop",   cnt_w[0],  7);
        for (int i = 0; i < 8; i++) expect_frame(0, 8'(i), -1, 0, 8'h00);
        chk("burst_empty_end", empty_w[0], 1);
        chk("burst_ovr_sticky", ovr_w[0], 1);
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        chk("burst_ovr_cleared", ovr_w[0], 0);

        // Enable dropped in DATA with two bytes queued
        b1 = 8'($urandom); b2 = 8'($urandom);
        ld0 = 1'b1; data0 = b1;
        tick();
        data0 = b2;
        tick();
        ld0 = 1'b0;
        chk("drop_start", line_w[0], 0);
        chk("drop_count_collide", cnt_w[0], 1);
        expect_frame(0, b1, 40, 1, 8'h00);
        chk("drop_count_kept", cnt_w[0], 1);
        chk("drop_busy_low",   busy_w[0], 0);
        chk("drop_empty_low",  empty_w[0], 0);
        errs = 0;
        repeat (20) begin
            if (line_w[0] !== 1'b1) errs++;
            tick();
        end
        chk("drop_line_idle", errs, 0);
        en0 = 1'b1;
        tick();
        chk("reenable_start_next_edge", line_w[0], 0);
        expect_frame(0, b2, -1, 0, 8'h00);
        chk("drop_empty_end", empty_w[0], 1);

        // Push on the exact pop edge with tx_count=3
        for (int i = 0; i < 5; i++) cb[i] = 8'($urandom);
        en0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ld0 = 1'b1; data0 = cb[i];
            tick();
        end
        ld0 = 1'b0;
        chk("coll_count4", cnt_w[0], 4);
        en0 = 1'b1;
        tick();
        chk("coll_count3", cnt_w[0], 3);
        expect_frame(0, cb[0], 159, 2, cb[4]);
        chk("coll_count_unchanged", cnt_w[0], 3);
        chk("coll_gapless", line_w[0], 0);
        for (int i = 1; i < 5; i++) expect_frame(0, cb[i], -1, 0, 8'h00);
        chk("coll_empty_end", empty_w[0], 1);

        // Randomized writes vs. queue model
        exp_q.delete();
        fork
            begin : writer
                for (int n = 0; n < 12; n++) begin
                    int g, w;
                    g = $urandom_range(0, 200);
                    repeat (g) tick();
                    w = 0;
                    while (exp_q.size() >= 5 && w < 5000) begin tick(); w++; end
                    ld0 = 1'b1; data0 = 8'($urandom);
                    exp_q.push_back(data0);
                    tick();
                    ld0 = 1'b0;
                end
            end
            begin : reader
                for (int n = 0; n < 12; n++) begin
                    logic [7:0] eb;
                    bit         got;
                    wait_start(0, 5000, got);
                    if (!got) break;
                    chk("rand_model_nonempty", (exp_q.size() > 0), 1);
                    eb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                    expect_frame(0, eb, -1, 0, 8'h00);
                end
            end
        join
        ld0 = 1'b0;
        repeat (2) tick();
        chk("rand_empty_end", empty_w[0], 1);
        chk("rand_model_drained", exp_q.size(), 0);

        // Parity (even/odd) and CLKS_PER_BIT=2 on the shared-input instances
        en1 = 1'b1;
        for (int r = 0; r < 2; r++) begin
            logic [7:0] pb;
            pb = (r == 0) ? 8'h07 : 8'($urandom);
            ld1 = 1'b1; data1 = pb;
            tick();
            ld1 = 1'b0;
            tick();
            for (int s = 1; s < 4; s++) chk($sformatf("par_r%0d_s%0d_start", r, s), line_w[s], 0);
            fork
                expect_frame(1, pb, -1, 0, 8'h00);
                expect_frame(2, pb, -1, 0, 8'h00);
                expect_frame(3, pb, -1, 0, 8'h00);
            join
            chk($sformatf("par_r%0d_even_empty_176", r), empty_w[1], 1);
            chk($sformatf("par_r%0d_odd_empty_176", r),  empty_w[2], 1);
            chk($sformatf("par_r%0d_fast_empty", r),     empty_w[3], 1);
        end
        en1 = 1'b0;

        // Reset in the middle of DATA
        ld0 = 1'b1; data0 = 8'h00;
        tick();
        tick();
        ld0 = 1'b0;
        repeat (36) tick();
        chk("midrst_line_low_before", line_w[0], 0);
        chk("midrst_count_before",    cnt_w[0],  1);
        reset_n = 1'b0;
        #1;
        chk("midrst_line_async", line_w[0], 1);
        chk("midrst_count_async", cnt_w[0], 0);
        #2;
        reset_n = 1'b1;
        tick();
        chk("midrst_count_after", cnt_w[0], 0);
        chk("midrst_busy_after",  busy_w[0], 0);
        chk("midrst_empty_after", empty_w[0], 1);
        errs = 0;
        repeat (40) begin
            if (line_w[0] !== 1'b1) errs++;
            tick();
        end
        chk("midrst_no_restart", errs, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Single-clock buffered UART transmitter: accepts bytes into an 8-entry FIFO and serialises them as 8N1 frames (optional parity), LSB first, at a rate set by an internal baud divider. It is the transmit end paired with the 16x-oversampling UART receiver. `CLKS_PER_BIT` = 16 with the receiver's `rxclk` equal to `txclk` gives a matched link. It replaces the unbuffered baud-clocked transmitter where the host writes bursts.

## Interface
- `CLKS_PER_BIT`, 16: `txclk` cycles per serial bit. Legal range is 2..65535.
- `FIFO_DEPTH`, 8: FIFO entries. Must be a power of 2, 2..16.
- `PARITY_EN`, 0: 1 inserts a parity bit between the last data bit and the stop bit.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd parity. Ignored when `PARITY_EN` = 0.

- `txclk` in 1: the single clock. All logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ld_tx_data` in 1: write strobe. `tx_data` is pushed on every cycle this is high.
- `tx_data` in 8: byte to push.
- `tx_enable` in 1: permits starting new frames.
- `clr_over_run` in 1: clears `tx_over_run`.
- `tx_out` out 1: serial line. Idle level is 1.
- `tx_full` out 1: FIFO holds `FIFO_DEPTH` entries.
- `tx_empty` out 1: FIFO empty and FSM in IDLE.
- `tx_busy` out 1: FSM not in IDLE.
- `tx_count` out 5: FIFO occupancy, 0..`FIFO_DEPTH`.
- `tx_over_run` out 1: sticky flag, set when a write is dropped.

## Operation
- **Reset values.** `tx_out`=1, `tx_full`=0, `tx_empty`=1, `tx_busy`=0, `tx_count`=0, `tx_over_run`=0. FIFO pointers and the baud counter are 0 and the FSM is IDLE.
- **Reset mid-frame.** The frame is aborted, `tx_out` returns to 1 immediately (asynchronously), and FIFO contents are discarded.
- **FIFO write.** A write occurs when `ld_tx_data` is high and `tx_full` is low. `tx_full` is evaluated as of the start of the cycle.
- **Write while full.** The byte is dropped and `tx_over_run` is set, even if a pop happens in the same cycle.
- **Simultaneous push and pop.** When not full, both happen and `tx_count` is unchanged.
- **`tx_over_run` clearing.** The flag stays high until `clr_over_run`. If set and clear occur in the same cycle, set wins.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when `tx_enable` is high and the FIFO is not empty. In that cycle the head byte is popped into the shift register and the baud counter is cleared.
  - START drives `tx_out`=0 for `CLKS_PER_BIT` cycles, then → DATA.
  - DATA drives `shift[0]`, shifts right after each bit, and uses a 3-bit bit index. After bit 7, → PARITY if `PARITY_EN`, otherwise → STOP.
  - PARITY drives `^data` (even), or `~^data` when `PARITY_ODD`, computed from the popped byte.
  - STOP drives `tx_out`=1 for `CLKS_PER_BIT` cycles.
  - At the end of STOP, if `tx_enable` is high and the FIFO is not empty, the FSM pops and goes directly to START with no idle bit. Otherwise it goes to IDLE.
- **Baud counter.** Counts 0..`CLKS_PER_BIT`-1 and wraps to 0 at each bit boundary. Width is `$clog2(CLKS_PER_BIT)`.
- **Deasserting `tx_enable`.** The frame in progress completes. No new frame starts. FIFO contents are retained.
- **Writes during transmission.** Writes are accepted at any time, independent of FSM state.

## Timing
- **First-frame latency.** For a write at edge N into an empty FIFO with the FSM idle and enabled:
  - `tx_count`=1 after edge N.
  - Pop occurs at edge N+1.
  - `tx_out` falls after edge N+1 and `tx_busy` goes high after edge N+1.
- **Frame length.** (10 + `PARITY_EN`) × `CLKS_PER_BIT` cycles, from the `tx_out` falling edge to the end of the stop bit.
- **Back-to-back frames.** The next start bit begins on the cycle immediately after the last stop-bit cycle.
- **Registered outputs.** `tx_out` is registered with no combinational path from the inputs. All status outputs are registered and updated one edge after the causing event.
- **`tx_empty`.** Goes high on the edge where the FSM returns to IDLE with the FIFO empty.

## Test plan
- **Reset.** Hold `reset_n`=0 with random inputs → all outputs at reset values. Assert `reset_n`=0 mid-DATA → `tx_out`=1 immediately and `tx_count`=0 after release.
- **Single byte.** Default parameters, `tx_enable`=1, write 0xA5 → `tx_out` low 2 edges after the write. Line sequence 0,1,0,1,0,0,1,0,1,1, each held exactly 16 cycles. `tx_empty` high after 160 cycles.
- **Burst to full.** `tx_enable`=0, write 9 bytes 0x00..0x08 → `tx_full`=1 and `tx_count`=8 after 8 writes. The 9th write is dropped and `tx_over_run`=1. Then enable → 8 gapless frames 0x00..0x07, 1280 cycles total. `clr_over_run` → flag 0.
- **Parity.** `PARITY_EN`=1, `PARITY_ODD`=0, byte 0x07 → parity bit 1 and frame of 176 cycles. With `PARITY_ODD`=1 → parity bit 0.
- **Enable drop.** Deassert `tx_enable` in DATA of frame 1 with 2 bytes queued → frame 1 completes, line stays 1, `tx_count`=1. Re-enable → frame 2 starts on the next edge.
- **Push/pop collision.** Write on exactly the pop edge with `tx_count`=3 → `tx_count` stays 3 and byte order is preserved. `CLKS_PER_BIT`=2 → each bit lasts 2 cycles.
